// File: rtl/multi_tick_counter.sv
// Bank of independent prescaled up/down counters with per-channel divisor and limit,
// plus a free-running heartbeat blink and an LED nibble mirrored from one channel.
module multi_tick_counter #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int NUM_CH       = 4,
    parameter int BIT_WIDTH    = 32,
    parameter int DVSR_W       = 32,
    parameter int DEFAULT_DVSR = 50_000_000,
    parameter int LED_CH       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [NUM_CH-1:0]           ch_up,
    input  logic [NUM_CH-1:0]           ch_oneshot,
    input  logic [NUM_CH-1:0]           clr,
    input  logic                        cfg_wr,
    input  logic [$clog2(NUM_CH):0]     cfg_ch,
    input  logic [DVSR_W-1:0]           cfg_dvsr,
    input  logic [BIT_WIDTH-1:0]        cfg_limit,
    output logic [NUM_CH*BIT_WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]           tc_pulse,
    output logic [NUM_CH-1:0]           done,
    output logic                        heartbeat,
    output logic [3:0]                  led
);

    localparam int CH_W = $clog2(NUM_CH) + 1;
    localparam int HB_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    localparam logic [DVSR_W-1:0]    DVSR_RST = DVSR_W'(DEFAULT_DVSR);
    localparam logic [DVSR_W-1:0]    Q_ONE    = DVSR_W'(1);
    localparam logic [BIT_WIDTH-1:0] CNT_ONE  = BIT_WIDTH'(1);
    localparam logic [HB_W-1:0]      HB_LAST  = HB_W'(CLK_FREQ - 1);
    localparam logic [HB_W-1:0]      HB_ONE   = HB_W'(1);

    logic [NUM_CH-1:0][DVSR_W-1:0]    q_q, q_d;
    logic [NUM_CH-1:0][DVSR_W-1:0]    dvsr_q, dvsr_d;
    logic [NUM_CH-1:0][BIT_WIDTH-1:0] count_q, count_d;
    logic [NUM_CH-1:0][BIT_WIDTH-1:0] limit_q, limit_d;
    logic [NUM_CH-1:0]                done_q, done_d;
    logic [NUM_CH-1:0]                tc_q, tc_d;
    logic [NUM_CH-1:0]                tick;
    logic [NUM_CH-1:0]                cfg_hit;

    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            heartbeat_q, heartbeat_d;
    logic            hb_wrap;
    logic [3:0]      led_q, led_d;

    always_comb begin
        tick    = '0;
        cfg_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tick[i]    = ch_en[i] && (q_q[i] == dvsr_q[i]);
            cfg_hit[i] = cfg_wr && (cfg_ch == CH_W'(i));
        end
    end

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        dvsr_d  = dvsr_q;
        limit_d = limit_q;
        done_d  = done_q;
        tc_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_en[i]) begin
                q_d[i] = tick[i] ? '0 : q_q[i] + Q_ONE;
            end

            // A completed one-shot ignores ticks until clr or a cfg write rearms it.
            if (tick[i] && !(ch_oneshot[i] && done_q[i])) begin
                if (ch_up[i]) begin
                    if (count_q[i] < limit_q[i]) begin
                        count_d[i] = count_q[i] + CNT_ONE;
                    end else begin
                        tc_d[i] = 1'b1;
                        if (ch_oneshot[i]) begin
                            done_d[i] = 1'b1;
                        end else begin
                            count_d[i] = '0;
                        end
                    end
                end else begin
                    if (count_q[i] != '0) begin
                        count_d[i] = count_q[i] - CNT_ONE;
                    end else begin
                        tc_d[i] = 1'b1;
                        if (ch_oneshot[i]) begin
                            done_d[i] = 1'b1;
                        end else begin
                            count_d[i] = limit_q[i];
                        end
                    end
                end
            end

            if (cfg_hit[i]) begin
                dvsr_d[i]  = cfg_dvsr;
                limit_d[i] = cfg_limit;
                q_d[i]     = '0;
                done_d[i]  = 1'b0;
            end

            // clr overrides any same-cycle tick; the down reload sees a same-cycle cfg limit.
            if (clr[i]) begin
                q_d[i]     = '0;
                done_d[i]  = 1'b0;
                tc_d[i]    = 1'b0;
                count_d[i] = ch_up[i] ? '0 : limit_d[i];
            end
        end
    end

    always_comb begin
        hb_wrap     = (hb_cnt_q == HB_LAST);
        hb_cnt_d    = hb_wrap ? '0 : hb_cnt_q + HB_ONE;
        heartbeat_d = heartbeat_q ^ hb_wrap;
        led_d       = count_q[LED_CH][BIT_WIDTH-1 -: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q         <= '0;
            count_q     <= '0;
            dvsr_q      <= {NUM_CH{DVSR_RST}};
            limit_q     <= '1;
            done_q      <= '0;
            tc_q        <= '0;
            hb_cnt_q    <= '0;
            heartbeat_q <= 1'b0;
            led_q       <= '0;
        end else begin
            q_q         <= q_d;
            count_q     <= count_d;
            dvsr_q      <= dvsr_d;
            limit_q     <= limit_d;
            done_q      <= done_d;
            tc_q        <= tc_d;
            hb_cnt_q    <= hb_cnt_d;
            heartbeat_q <= heartbeat_d;
            led_q       <= led_d;
        end
    end

    assign count_out = count_q;
    assign tc_pulse  = tc_q;
    assign done      = done_q;
    assign heartbeat = heartbeat_q;
    assign led       = led_q;

endmodule

// File: tb/tb_multi_tick_counter.sv
// Directed bench for multi_tick_counter: hand-computed counts, pulses and flags per channel.
module tb_multi_tick_counter;

    logic        clk;
    logic        rst;
    logic [3:0]  ch_en;
    logic [3:0]  ch_up;
    logic [3:0]  ch_oneshot;
    logic [3:0]  clr;
    logic        cfg_wr;
    logic [2:0]  cfg_ch;
    logic [7:0]  cfg_dvsr;
    logic [7:0]  cfg_limit;
    logic [31:0] count_out;
    logic [3:0]  tc_pulse;
    logic [3:0]  done;
    logic        heartbeat;
    logic [3:0]  led;

    int n_checks;
    int n_errors;
    logic seen_tc;

    multi_tick_counter #(
        .CLK_FREQ(10), .NUM_CH(4), .BIT_WIDTH(8), .DVSR_W(8),
        .DEFAULT_DVSR(9), .LED_CH(0)
    ) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .ch_up(ch_up), .ch_oneshot(ch_oneshot),
        .clr(clr), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_dvsr(cfg_dvsr),
        .cfg_limit(cfg_limit), .count_out(count_out), .tc_pulse(tc_pulse),
        .done(done), .heartbeat(heartbeat), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt(input int i);
        return count_out[i*8 +: 8];
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        ch_en      = '0;
        ch_up      = '0;
        ch_oneshot = '0;
        clr        = '0;
        cfg_wr     = 1'b0;
        cfg_ch     = '0;
        cfg_dvsr   = '0;
        cfg_limit  = '0;

        step(2);
        check("rst_count", count_out, 32'h0);
        check("rst_tc", {28'h0, tc_pulse}, 32'h0);
        check("rst_done", {28'h0, done}, 32'h0);
        check("rst_hb", {31'h0, heartbeat}, 32'h0);
        check("rst_led", {28'h0, led}, 32'h0);
        rst = 1'b0;

        // ch0 up free-run, dvsr=3 limit=5
        cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_dvsr = 8'd3; cfg_limit = 8'd5; ch_up[0] = 1'b1;
        step(1);
        cfg_wr = 1'b0; ch_en[0] = 1'b1;
        step(4);
        check("up_first_tick", cnt(0), 1);
        step(16);
        check("up_at_limit", cnt(0), 5);
        check("up_no_tc_yet", tc_pulse[0], 0);
        step(4);
        check("up_wrap_count", cnt(0), 0);
        check("up_wrap_tc", tc_pulse[0], 1);
        step(1);
        check("up_tc_single", tc_pulse[0], 0);
        step(5);
        check("pause_before", cnt(0), 1);
        ch_en[0] = 1'b0;
        step(10);
        check("pause_frozen", cnt(0), 1);
        ch_en[0] = 1'b1;
        step(1);
        check("resume_q3", cnt(0), 1);
        step(1);
        check("resume_tick", cnt(0), 2);
        ch_en[0] = 1'b0;

        // ch1 down one-shot with cfg+clr in the same cycle
        cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_dvsr = 8'd0; cfg_limit = 8'd3;
        ch_up[1] = 1'b0; ch_oneshot[1] = 1'b1; clr[1] = 1'b1;
        step(1);
        check("cfg_clr_reload", cnt(1), 3);
        cfg_wr = 1'b0; clr[1] = 1'b0; ch_en[1] = 1'b1;
        step(1);
        check("down_2", cnt(1), 2);
        step(1);
        check("down_1", cnt(1), 1);
        step(1);
        check("down_0", cnt(1), 0);
        check("down_done_early", done[1], 0);
        step(1);
        check("os_tc", tc_pulse[1], 1);
        check("os_done", done[1], 1);
        check("os_count", cnt(1), 0);
        seen_tc = 1'b0;
        repeat (20) begin
            step(1);
            seen_tc = seen_tc | tc_pulse[1];
        end
        check("os_no_more_tc", seen_tc, 0);
        check("os_hold", cnt(1), 0);
        check("os_sticky", done[1], 1);
        ch_en[1] = 1'b0; clr[1] = 1'b1;
        step(1);
        clr[1] = 1'b0;
        check("clr_done", done[1], 0);
        check("clr_down_reload", cnt(1), 3);

        // ch2 clr coinciding with a terminal one-shot tick
        cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_dvsr = 8'd0; cfg_limit = 8'd7;
        ch_up[2] = 1'b1; ch_oneshot[2] = 1'b1;
        step(1);
        cfg_wr = 1'b0; ch_en[2] = 1'b1;
        step(7);
        check("ch2_at7", cnt(2), 7);
        clr[2] = 1'b1;
        step(1);
        clr[2] = 1'b0;
        check("clr_beats_tick_cnt", cnt(2), 0);
        check("clr_beats_tick_tc", tc_pulse[2], 0);
        check("clr_beats_tick_done", done[2], 0);
        step(1);
        check("ch2_after_clr", cnt(2), 1);
        ch_en[2] = 1'b0;

        // ch3 divisor change mid-prescale, then an out-of-range cfg write
        ch_up[3] = 1'b1; ch_en[3] = 1'b1;
        step(5);
        cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_dvsr = 8'd1; cfg_limit = 8'hFF;
        step(1);
        cfg_wr = 1'b0;
        check("cfg_count_kept", cnt(3), 0);
        step(1);
        check("cfg_q_restart", cnt(3), 0);
        step(1);
        check("cfg_new_tick", cnt(3), 1);
        cfg_wr = 1'b1; cfg_ch = 3'd4; cfg_dvsr = 8'd0; cfg_limit = 8'd0;
        step(1);
        cfg_wr = 1'b0; ch_en[0] = 1'b1;
        step(1);
        check("badch_ch3_cnt", cnt(3), 2);
        check("badch_ch3_tc", tc_pulse[3], 0);
        check("badch_ch0_cnt", cnt(0), 2);
        check("badch_ch0_tc", tc_pulse[0], 0);
        ch_en[0] = 1'b0; ch_en[3] = 1'b0;

        // led follows ch0 top nibble one cycle late
        cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_dvsr = 8'd0; cfg_limit = 8'hA5;
        ch_up[0] = 1'b0; clr[0] = 1'b1;
        step(1);
        cfg_wr = 1'b0; clr[0] = 1'b0;
        check("led_src", cnt(0), 8'hA5);
        check("led_lag", {28'h0, led}, 32'h0);
        step(1);
        check("led_value", {28'h0, led}, 32'hA);

        // limit=0 up free-run: stuck at 0 with tc every tick
        cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_dvsr = 8'd0; cfg_limit = 8'd0;
        ch_up[0] = 1'b1; clr[0] = 1'b1;
        step(1);
        cfg_wr = 1'b0; clr[0] = 1'b0;
        check("lim0_clr", cnt(0), 0);
        ch_en[0] = 1'b1;
        step(1);
        check("lim0_cnt", cnt(0), 0);
        check("lim0_tc_a", tc_pulse[0], 1);
        step(1);
        check("lim0_tc_b", tc_pulse[0], 1);
        ch_en[0] = 1'b0;

        // ch1 down free-run reload from limit
        ch_oneshot[1] = 1'b0; ch_en[1] = 1'b1;
        step(3);
        check("dfr_zero", cnt(1), 0);
        step(1);
        check("dfr_reload", cnt(1), 3);
        check("dfr_tc", tc_pulse[1], 1);
        step(2);

        // async reset mid-count, then heartbeat period
        rst = 1'b1;
        #1;
        check("arst_count", count_out, 32'h0);
        check("arst_tc", {28'h0, tc_pulse}, 32'h0);
        check("arst_done", {28'h0, done}, 32'h0);
        check("arst_led", {28'h0, led}, 32'h0);
        check("arst_hb", {31'h0, heartbeat}, 32'h0);
        ch_en = '0; ch_up = '0; ch_oneshot = '0; clr = '0;
        rst = 1'b0;
        step(9);
        check("hb_before", heartbeat, 0);
        step(1);
        check("hb_toggle", heartbeat, 1);
        check("idle_count", count_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
